// File: rtl/com_uart.sv
// com_uart: UART responder behind the CPU's COM data/status registers.
// Sends one 8N1 frame per write strobe and buffers the 8N1 frames it receives.
// Optional feature macro: COM_RX_FIFO_EN (receive FIFO instead of holding register).
//
// Ports:
//   clk50M           in   system clock, rising edge
//   rst              in   asynchronous active-high reset
//   com_data_out     in   byte to transmit
//   enable_com_write in   one-cycle transmit request
//   int_com_ack      in   read acknowledge, rising edge pops one byte
//   com_data_in      out  oldest unread received byte
//   com_read_ready   out  a received byte is waiting
//   com_write_ready  out  transmitter idle
//   uart_rxd         in   serial input (asynchronous)
//   uart_txd         out  serial output, idles high

module com_uart #(
    parameter int CLK_FREQ      = 50000000,
    parameter int BAUD          = 115200,
    parameter int RX_FIFO_DEPTH = 8
) (
    input  logic       clk50M,
    input  logic       rst,
    input  logic [7:0] com_data_out,
    input  logic       enable_com_write,
    input  logic       int_com_ack,
    output logic [7:0] com_data_in,
    output logic       com_read_ready,
    output logic       com_write_ready,
    input  logic       uart_rxd,
    output logic       uart_txd
);

    localparam int DIV = CLK_FREQ / BAUD;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] C_FULL = CW'(DIV - 1);
    localparam logic [CW-1:0] C_HALF = CW'(DIV / 2 - 1);

    if (RX_FIFO_DEPTH < 2 ||
        (RX_FIFO_DEPTH & (RX_FIFO_DEPTH - 1)) != 0) begin : g_depth_chk
        $error("com_uart: RX_FIFO_DEPTH must be a power of two >= 2");
    end

    // ------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------
    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    tx_state_t     r_tx_state;
    tx_state_t     w_tx_next;
    logic [CW-1:0] r_tx_cnt;
    logic [2:0]    r_tx_bit;
    logic [7:0]    r_tx_byte;
    logic          w_tx_tick;
    logic          w_txd;
    logic          w_tx_ready;

    assign w_tx_tick = (r_tx_cnt == '0);

    always_ff @(posedge clk50M or posedge rst) begin
        if (rst) begin
            r_tx_state <= TX_IDLE;
        end else begin
            r_tx_state <= w_tx_next;
        end
    end

    always_comb begin
        w_tx_next = r_tx_state;
        case (r_tx_state)
            TX_IDLE: begin
                if (enable_com_write) begin
                    w_tx_next = TX_START;
                end
            end
            TX_START: begin
                if (w_tx_tick) begin
                    w_tx_next = TX_DATA;
                end
            end
            TX_DATA: begin
                if (w_tx_tick && r_tx_bit == 3'd7) begin
                    w_tx_next = TX_STOP;
                end
            end
            TX_STOP: begin
                if (w_tx_tick) begin
                    w_tx_next = TX_IDLE;
                end
            end
            default: w_tx_next = TX_IDLE;
        endcase
    end

    always_comb begin
        w_txd      = 1'b1;
        w_tx_ready = 1'b0;
        case (r_tx_state)
            TX_IDLE:  w_tx_ready = 1'b1;
            TX_START: w_txd      = 1'b0;
            TX_DATA:  w_txd      = r_tx_byte[r_tx_bit];
            default:  w_txd      = 1'b1;
        endcase
    end

    // Counter is held at DIV-1 while idle so START gets a full bit time.
    always_ff @(posedge clk50M or posedge rst) begin
        if (rst) begin
            r_tx_cnt  <= '0;
            r_tx_bit  <= '0;
            r_tx_byte <= '0;
        end else if (r_tx_state == TX_IDLE) begin
            r_tx_cnt <= C_FULL;
            r_tx_bit <= '0;
            if (enable_com_write) begin
                r_tx_byte <= com_data_out;
            end
        end else if (w_tx_tick) begin
            r_tx_cnt <= C_FULL;
            if (r_tx_state == TX_DATA) begin
                r_tx_bit <= r_tx_bit + 3'd1;
            end
        end else begin
            r_tx_cnt <= r_tx_cnt - 1'b1;
        end
    end

    assign uart_txd        = w_txd;
    assign com_write_ready = w_tx_ready;

    // ------------------------------------------------------------
    // Receiver front end
    // ------------------------------------------------------------
    logic r_rx_meta;
    logic r_rx_sync;
    logic r_rx_prev;
    logic w_rx_fall;

    always_ff @(posedge clk50M or posedge rst) begin
        if (rst) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_meta <= uart_rxd;
            r_rx_sync <= r_rx_meta;
            r_rx_prev <= r_rx_sync;
        end
    end

    assign w_rx_fall = r_rx_prev & ~r_rx_sync;

    // ------------------------------------------------------------
    // Receiver FSM
    // ------------------------------------------------------------
    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_WAIT_HIGH
    } rx_state_t;

    rx_state_t     r_rx_state;
    rx_state_t     w_rx_next;
    logic [CW-1:0] r_rx_cnt;
    logic [2:0]    r_rx_bit;
    logic [7:0]    r_rx_shift;
    logic          w_rx_tick;
    logic          w_rx_push;

    assign w_rx_tick = (r_rx_cnt == '0);

    always_ff @(posedge clk50M or posedge rst) begin
        if (rst) begin
            r_rx_state <= RX_IDLE;
        end else begin
            r_rx_state <= w_rx_next;
        end
    end

    always_comb begin
        w_rx_next = r_rx_state;
        case (r_rx_state)
            RX_IDLE: begin
                if (w_rx_fall) begin
                    w_rx_next = RX_START;
                end
            end
            RX_START: begin
                if (w_rx_tick) begin
                    w_rx_next = r_rx_sync ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (w_rx_tick && r_rx_bit == 3'd7) begin
                    w_rx_next = RX_STOP;
                end
            end
            RX_STOP: begin
                if (w_rx_tick) begin
                    w_rx_next = r_rx_sync ? RX_IDLE : RX_WAIT_HIGH;
                end
            end
            RX_WAIT_HIGH: begin
                if (r_rx_sync) begin
                    w_rx_next = RX_IDLE;
                end
            end
            default: w_rx_next = RX_IDLE;
        endcase
    end

    always_comb begin
        w_rx_push = 1'b0;
        case (r_rx_state)
            RX_STOP: w_rx_push = w_rx_tick & r_rx_sync;
            default: w_rx_push = 1'b0;
        endcase
    end

    // Idle preloads the half-bit delay so START samples mid-bit.
    always_ff @(posedge clk50M or posedge rst) begin
        if (rst) begin
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            r_rx_shift <= '0;
        end else if (r_rx_state == RX_IDLE) begin
            r_rx_cnt <= C_HALF;
            r_rx_bit <= '0;
        end else if (w_rx_tick) begin
            r_rx_cnt <= C_FULL;
            if (r_rx_state == RX_DATA) begin
                r_rx_shift <= {r_rx_sync, r_rx_shift[7:1]};
                r_rx_bit   <= r_rx_bit + 3'd1;
            end
        end else begin
            r_rx_cnt <= r_rx_cnt - 1'b1;
        end
    end

    // ------------------------------------------------------------
    // Read acknowledge edge detect
    // ------------------------------------------------------------
    logic r_ack_d;
    logic w_empty;
    logic w_pop;

    always_ff @(posedge clk50M or posedge rst) begin
        if (rst) begin
            r_ack_d <= 1'b0;
        end else begin
            r_ack_d <= int_com_ack;
        end
    end

    assign w_pop = int_com_ack & ~r_ack_d & ~w_empty;

    // ------------------------------------------------------------
    // Receive buffer
    // ------------------------------------------------------------
`ifdef COM_RX_FIFO_EN
    localparam int AW = $clog2(RX_FIFO_DEPTH);

    logic [7:0] r_mem [RX_FIFO_DEPTH];
    logic [AW:0] r_wptr;
    logic [AW:0] r_rptr;
    logic        w_full;
    logic        w_wr;

    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[AW] != r_rptr[AW]) &&
                     (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    // A pop in the same cycle frees the slot the push lands in.
    assign w_wr    = w_rx_push & (~w_full | w_pop);

    always_ff @(posedge clk50M or posedge rst) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
            for (int i = 0; i < RX_FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_wr) begin
                r_mem[r_wptr[AW-1:0]] <= r_rx_shift;
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
        end
    end

    assign com_data_in    = r_mem[r_rptr[AW-1:0]];
    assign com_read_ready = ~w_empty;
`else
    logic [7:0] r_hold;
    logic       r_hold_vld;
    logic       w_wr;

    assign w_empty = ~r_hold_vld;
    assign w_wr    = w_rx_push & (~r_hold_vld | w_pop);

    always_ff @(posedge clk50M or posedge rst) begin
        if (rst) begin
            r_hold     <= '0;
            r_hold_vld <= 1'b0;
        end else if (w_wr) begin
            r_hold     <= r_rx_shift;
            r_hold_vld <= 1'b1;
        end else if (w_pop) begin
            r_hold_vld <= 1'b0;
        end
    end

    assign com_data_in    = r_hold;
    assign com_read_ready = r_hold_vld;
`endif

endmodule

// File: tb/tb_com_uart.sv
// Testbench for com_uart at DIV=16: queue-based scoreboard with
// line-level TX decoder and ack-driven RX pop monitor.

module tb_com_uart;

    localparam int CLK_FREQ = 160;
    localparam int BAUD     = 10;
    localparam int DIV      = CLK_FREQ / BAUD;
    localparam int DEPTH    = 8;
`ifdef COM_RX_FIFO_EN
    localparam int CAP = DEPTH;
`else
    localparam int CAP = 1;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] com_data_out = 8'h00;
    logic       enable_com_write = 1'b0;
    logic       int_com_ack = 1'b0;
    logic [7:0] com_data_in;
    logic       com_read_ready;
    logic       com_write_ready;
    logic       uart_rxd = 1'b1;
    logic       uart_txd;

    com_uart #(
        .CLK_FREQ      (CLK_FREQ),
        .BAUD          (BAUD),
        .RX_FIFO_DEPTH (DEPTH)
    ) dut (
        .clk50M           (clk),
        .rst              (rst),
        .com_data_out     (com_data_out),
        .enable_com_write (enable_com_write),
        .int_com_ack      (int_com_ack),
        .com_data_in      (com_data_in),
        .com_read_ready   (com_read_ready),
        .com_write_ready  (com_write_ready),
        .uart_rxd         (uart_rxd),
        .uart_txd         (uart_txd)
    );

    always #5 clk = ~clk;

    int ncmp = 0;
    int nerr = 0;
    int cyc = 0;
    int tx_free = 0;
    logic [7:0] tx_exp[$];
    logic [7:0] rx_exp[$];

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Model: the transmitter is busy for 10*DIV cycles after an accepted strobe.
    task automatic tx_strobe(input logic [7:0] b);
        chk("tx_ready", 32'(com_write_ready), 32'(cyc >= tx_free));
        if (cyc >= tx_free) begin
            tx_exp.push_back(b);
            tx_free = cyc + 1 + 10 * DIV;
        end
        com_data_out = b;
        enable_com_write = 1'b1;
        step(1);
        enable_com_write = 1'b0;
    endtask

    task automatic tx_wave(input logic [7:0] b);
        int bad;
        logic [9:0] fr;
        bad = 0;
        fr = {1'b1, b, 1'b0};
        for (int k = 0; k < 10 * DIV; k++) begin
            @(negedge clk);
            if (uart_txd !== fr[k / DIV] || com_write_ready !== 1'b0) bad++;
        end
        @(negedge clk);
        chk("tx_wave_bad_cycles", 32'(bad), 32'd0);
        chk("tx_ready_after", 32'({com_write_ready, uart_txd}), 32'd3);
    endtask

    task automatic wait_tx_idle();
        while (cyc < tx_free) step(1);
    endtask

    task automatic rx_send(input logic [7:0] b, input logic stop);
        uart_rxd = 1'b0;
        step(DIV);
        for (int i = 0; i < 8; i++) begin
            uart_rxd = b[i];
            step(DIV);
        end
        uart_rxd = stop;
        step(DIV);
        uart_rxd = 1'b1;
        step(4);
        if (stop && rx_exp.size() < CAP) rx_exp.push_back(b);
    endtask

    task automatic rx_read(input int hold);
        chk("rx_ready", 32'(com_read_ready), 32'(rx_exp.size() > 0));
        int_com_ack = 1'b1;
        step(hold);
        int_com_ack = 1'b0;
        step(1);
    endtask

    // RX pop monitor: a rising ack is a read of the current head.
    logic       ack_prev = 1'b0;
    logic [7:0] mon_rx_e;
    always @(negedge clk) begin
        if (int_com_ack && !ack_prev && !rst) begin
            if (rx_exp.size() == 0) begin
                chk("rx_pop_empty", 32'(com_read_ready), 32'd0);
            end else begin
                mon_rx_e = rx_exp.pop_front();
                chk("rx_pop_ready", 32'(com_read_ready), 32'd1);
                chk("rx_pop_data", 32'(com_data_in), 32'(mon_rx_e));
            end
        end
        ack_prev = int_com_ack;
    end

    // TX line decoder: samples each bit mid-way, drops frames hit by reset.
    logic [9:0] txm_frame;
    logic       txm_abort;
    logic [7:0] txm_e;
    always begin
        @(negedge clk);
        if (!rst && uart_txd === 1'b0) begin
            txm_abort = 1'b0;
            txm_frame = '0;
            for (int i = 1; i <= 9 * DIV + DIV / 2; i++) begin
                @(negedge clk);
                if (rst) txm_abort = 1'b1;
                if (i % DIV == DIV / 2) txm_frame[i / DIV] = uart_txd;
            end
            if (!txm_abort) begin
                if (tx_exp.size() == 0) begin
                    ncmp++;
                    nerr++;
                    $display("FAIL tx_unexpected: got frame %0h expected none",
                             txm_frame[8:1]);
                end else begin
                    txm_e = tx_exp.pop_front();
                    chk("tx_data", 32'(txm_frame[8:1]), 32'(txm_e));
                    chk("tx_framing", 32'({txm_frame[9], txm_frame[0]}), 32'd2);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        step(3);
        chk("rst_txd", 32'(uart_txd), 32'd1);
        chk("rst_wr_ready", 32'(com_write_ready), 32'd1);
        chk("rst_rd_ready", 32'(com_read_ready), 32'd0);
        chk("rst_data_in", 32'(com_data_in), 32'd0);
        rst = 1'b0;
        step(2);

        // Frame waveform, with a strobe issued mid-frame that must be lost.
        tx_strobe(8'hA5);
        fork
            tx_wave(8'hA5);
            begin
                step(50);
                tx_strobe(8'h3C);
            end
        join
        step(1);

        // Single receive, ack held several cycles.
        rx_send(8'h5A, 1'b1);
        chk("rx_ready_5a", 32'(com_read_ready), 32'd1);
        chk("rx_head_5a", 32'(com_data_in), 32'h5A);
        rx_read(3);
        chk("rx_ready_after_pop", 32'(com_read_ready), 32'(rx_exp.size() > 0));

        // Glitch shorter than half a bit.
        uart_rxd = 1'b0;
        step(4);
        uart_rxd = 1'b1;
        step(3 * DIV);
        chk("rx_glitch", 32'(com_read_ready), 32'(rx_exp.size() > 0));

        // Framing error, then a good frame.
        rx_send(8'h77, 1'b0);
        chk("rx_framing", 32'(com_read_ready), 32'(rx_exp.size() > 0));
        rx_send(8'h11, 1'b1);
        rx_read(1);

        // Overflow: more bytes than the buffer holds, no ack.
        for (int b = 1; b <= 9; b++) rx_send(8'(b), 1'b1);
        for (int i = 0; i <= CAP; i++) rx_read(2);
        chk("rx_overflow_empty", 32'(com_read_ready), 32'd0);

        // Asynchronous reset in the middle of data bit 4.
        wait_tx_idle();
        tx_strobe(8'hC3);
        step(5 * DIV + 3);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_mid_txd", 32'(uart_txd), 32'd1);
        chk("rst_mid_wr_ready", 32'(com_write_ready), 32'd1);
        tx_exp.delete();
        rx_exp.delete();
        tx_free = 0;
        step(2);
        rst = 1'b0;
        step(12 * DIV);
        tx_strobe(8'hFF);
        tx_wave(8'hFF);
        step(1);

        // Randomised mix of writes, receives, reads and idle time.
        for (int it = 0; it < 60; it++) begin
            case ($urandom_range(0, 3))
                0: tx_strobe(8'($urandom()));
                1: rx_send(8'($urandom()), $urandom_range(0, 7) != 0);
                2: rx_read($urandom_range(1, 4));
                default: step($urandom_range(1, 40));
            endcase
        end

        while (rx_exp.size() > 0) rx_read(1);
        rx_read(1);
        wait_tx_idle();
        step(2 * DIV);
        chk("tx_drain", 32'(tx_exp.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
